// File: rtl/uart_rx_sipo.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_sipo
// Brief   : UART receive front end: line sync, start validation, mid-bit
//           sampling and assembly of the 11-bit {stop,parity,data,start} frame.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sipo #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        baud_tick,
    input  logic        rx_serial,
    input  logic        rx_enable,
    output logic [10:0] data_parll,
    output logic        recieved_flag,
    output logic        frame_err,
    output logic        busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt, tick_n;
    logic [3:0]             bit_cnt, bit_n;
    logic [10:0]            shift_q, shift_n;
    logic                   armed, armed_n;

    // Flops preset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shift_q  <= shift_n;
            armed    <= armed_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        armed_n = 1'b0;
        case (state)
            IDLE: begin
                armed_n = armed | rx_s;
                // armed blocks a held-low (break) line from retriggering.
                if (rx_enable && armed && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                    armed_n = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == HALF_M1) begin
                        tick_n = '0;
                        if (!rx_s) begin
                            shift_n = {rx_s, shift_q[10:1]};
                            bit_n   = 4'd1;
                            state_n = SHIFT;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift_q[10:1]};
                        bit_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            state_n = DONE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (!rx_enable) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_parll    <= '0;
            recieved_flag <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            recieved_flag <= 1'b0;
            if (state == DONE && rx_enable) begin
                data_parll    <= shift_q;
                frame_err     <= ~shift_q[10];
                recieved_flag <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire
